spi_slave_rx: RTL and testbench

SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_rx_fifo.sv | 51 +++++
 rtl/spi_slave_rx.sv | 181 ++++++++++++++++++
 tb/tb_spi_slave_rx.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI constants and receive FSM state type.
// Also used by the upstream master model and the checker.
`timescale 1ns / 1ps
package spi_pkg;

   localparam int unsigned SpiWidth      = 12;
   localparam int unsigned SpiSyncStages = 2;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StShift  = 2'd1,
      StWaitCs = 2'd2,
      StArm    = 2'd3
   } spi_state_e;

endpackage

// File: rtl/spi_rx_fifo.sv
// Power-of-two output FIFO for the SPI receiver; head entry is visible on rdata_o.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
`timescale 1ns / 1ps
module spi_rx_fifo #(
   parameter int unsigned WIDTH = 12,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [WIDTH-1:0] rdata_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q;
   logic [AW:0]      rd_ptr_q;
   logic             wr_en;
   logic             rd_en;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign wr_en   = push_i & (~full_o | pop_i);
   assign rd_en   = pop_i & ~empty_o;
   assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
            wr_ptr_q                <= wr_ptr_q + (AW + 1)'(1);
         end
         if (rd_en) begin
            rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
         end
      end
   end

endmodule

// File: rtl/spi_slave_rx.sv
// Receive-only SPI slave: synchronizes sclk/cs/mosi, samples mosi on sclk falling edges.
// Define SPI_SLAVE_RX_FIFO_EN for a FIFO_DEPTH-entry output FIFO; otherwise a single holding register.
`timescale 1ns / 1ps
module spi_slave_rx
   import spi_pkg::*;
#(
   parameter int unsigned WIDTH       = SpiWidth,
   parameter int unsigned SYNC_STAGES = SpiSyncStages,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sclk,
   input  logic             cs,
   input  logic             mosi,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             busy,
   output logic             frame_err,
   output logic             overflow
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);
   localparam int unsigned ArmW = $clog2(SYNC_STAGES + 1);

   if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of two of at least 2");
   end

   logic [SYNC_STAGES-1:0] sclk_sync_q;
   logic [SYNC_STAGES-1:0] cs_sync_q;
   logic [SYNC_STAGES-1:0] mosi_sync_q;
   logic                   sclk_prev_q;
   logic                   sclk_s;
   logic                   cs_s;
   logic                   mosi_s;
   logic                   sclk_fall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_sync_q <= '0;
         cs_sync_q   <= '1;
         mosi_sync_q <= '0;
         sclk_prev_q <= 1'b0;
      end else begin
         sclk_sync_q <= (sclk_sync_q << 1) | SYNC_STAGES'(sclk);
         cs_sync_q   <= (cs_sync_q << 1) | SYNC_STAGES'(cs);
         mosi_sync_q <= (mosi_sync_q << 1) | SYNC_STAGES'(mosi);
         sclk_prev_q <= sclk_s;
      end
   end

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign cs_s      = cs_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign sclk_fall = sclk_prev_q & ~sclk_s;

   spi_state_e       state_q;
   logic [CntW-1:0]  bit_cnt_q;
   logic [WIDTH-2:0] shift_q;
   logic [ArmW-1:0]  arm_cnt_q;
   logic             busy_q;
   logic             frame_err_q;
   logic             overflow_q;
   logic             push;
   logic [WIDTH-1:0] push_data;

   // The final bit bypasses shift_q and goes straight into storage with the earlier bits.
   assign push      = (state_q == StShift) && sclk_fall && (bit_cnt_q == CntW'(WIDTH - 1));
   assign push_data = {shift_q, mosi_s};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StArm;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         arm_cnt_q   <= '0;
         busy_q      <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         frame_err_q <= 1'b0;
         unique case (state_q)
            // Synchronizer reset levels fake cs high; wait until real samples have arrived.
            StArm: begin
               if (arm_cnt_q != ArmW'(SYNC_STAGES)) begin
                  arm_cnt_q <= arm_cnt_q + ArmW'(1);
               end else if (cs_s) begin
                  state_q <= StIdle;
               end
            end
            StIdle: begin
               if (!cs_s) begin
                  state_q   <= StShift;
                  bit_cnt_q <= '0;
                  shift_q   <= '0;
                  busy_q    <= 1'b1;
               end
            end
            StShift: begin
               if (sclk_fall) begin
                  shift_q   <= push_data[WIDTH-2:0];
                  bit_cnt_q <= bit_cnt_q + CntW'(1);
               end
               if (push) begin
                  state_q <= StWaitCs;
               end else if (cs_s) begin
                  frame_err_q <= 1'b1;
                  state_q     <= StIdle;
                  busy_q      <= 1'b0;
               end
            end
            StWaitCs: begin
               if (cs_s) begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end
            end
         endcase
      end
   end

   logic full;
   logic pop;
   logic accept;

   assign pop    = dout_valid & dout_ready;
   assign accept = push & (~full | pop);

`ifdef SPI_SLAVE_RX_FIFO_EN
   logic empty;

   spi_rx_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (accept),
      .wdata_i (push_data),
      .pop_i   (pop),
      .full_o  (full),
      .empty_o (empty),
      .rdata_o (dout)
   );

   assign dout_valid = ~empty;
`else
   logic [WIDTH-1:0] hold_q;
   logic             hold_valid_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
      end else if (accept) begin
         hold_q       <= push_data;
         hold_valid_q <= 1'b1;
      end else if (pop) begin
         hold_valid_q <= 1'b0;
      end
   end

   assign dout       = hold_q;
   assign dout_valid = hold_valid_q;
   assign full       = hold_valid_q;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= push & full & ~pop;
      end
   end

   assign busy      = busy_q;
   assign frame_err = frame_err_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Scoreboard bench for spi_slave_rx: a frame-level model queues expected words, a monitor checks pops.
`timescale 1ns / 1ps
module tb_spi_slave_rx;

   localparam int unsigned W  = 12;
   localparam int unsigned SS = 2;
   localparam int unsigned FD = 4;
`ifdef SPI_SLAVE_RX_FIFO_EN
   localparam int Depth = FD;
`else
   localparam int Depth = 1;
`endif
   localparam int H = 60;  // sclk half period: 6 clk cycles

   logic         clk = 1'b0;
   logic         rst;
   logic         sclk;
   logic         cs;
   logic         mosi;
   logic [W-1:0] dout;
   logic         dout_valid;
   logic         dout_ready = 1'b0;
   logic         busy;
   logic         frame_err;
   logic         overflow;

   spi_slave_rx #(
      .WIDTH       (W),
      .SYNC_STAGES (SS),
      .FIFO_DEPTH  (FD)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .sclk       (sclk),
      .cs         (cs),
      .mosi       (mosi),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .busy       (busy),
      .frame_err  (frame_err),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   int           checks = 0;
   int           errors = 0;
   int           ferr_seen = 0;
   int           ovf_seen = 0;
   int           ferr_exp = 0;
   int           ovf_exp = 0;
   int           ready_mode = 1;  // 0: hold low, 1: hold high, 2: random
   logic [W-1:0] exp_q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Reference model: a complete word is stored if there is room, otherwise it is dropped.
   task automatic model_word(input logic [W-1:0] v);
      if (exp_q.size() < Depth) exp_q.push_back(v);
      else ovf_exp++;
   endtask

   initial begin : ready_drv
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       dout_ready = 1'b0;
            1:       dout_ready = 1'b1;
            default: dout_ready = 1'($urandom_range(1, 0));
         endcase
      end
   end

   initial begin : monitor
      logic         prev_v = 1'b0;
      logic         prev_r = 1'b0;
      logic [W-1:0] prev_d = '0;
      logic [W-1:0] e;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_v = 1'b0;
         end else begin
            if (prev_v && !prev_r) begin
               checks++;
               if (!dout_valid || dout !== prev_d) begin
                  errors++;
                  $display("FAIL hold: got valid=%0b dout=%0h expected valid=1 dout=%0h",
                           dout_valid, dout, prev_d);
               end
            end
            if (dout_valid && dout_ready) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_word: got %0h expected none", dout);
               end else begin
                  e = exp_q.pop_front();
                  if (dout !== e) begin
                     errors++;
                     $display("FAIL word: got %0h expected %0h", dout, e);
                  end
               end
            end
            if (frame_err) ferr_seen++;
            if (overflow) ovf_seen++;
            prev_v = dout_valid;
            prev_r = dout_ready;
            prev_d = dout;
         end
      end
   end

   task automatic drive_bits(input logic [W-1:0] v, input int from, input int to,
                             input bit coincide, input bit capture);
      for (int i = from; i < to; i++) begin
         sclk = 1'b1;
         mosi = v[W-1-i];
         #H;
         sclk = 1'b0;
         if (capture && i == int'(W) - 1) model_word(v);
         if (coincide && i == to - 1) cs = 1'b1;
         #H;
      end
   endtask

   task automatic send_frame(input logic [W-1:0] v, input int nbits, input bit coincide);
      @(negedge clk);
      cs = 1'b0;
      #H;
      if (nbits > 3) begin
         drive_bits(v, 0, 3, 1'b0, 1'b0);
         check("busy_mid", 32'(busy), 32'd1);
         drive_bits(v, 3, nbits, coincide, nbits == int'(W));
      end else begin
         drive_bits(v, 0, nbits, coincide, nbits == int'(W));
      end
      if (nbits < int'(W)) ferr_exp++;
      if (!coincide) cs = 1'b1;
      #(2 * H);
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (exp_q.size() != 0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic check_counts(input string tag);
      check({tag, "_frame_err"}, 32'(ferr_seen), 32'(ferr_exp));
      check({tag, "_overflow"}, 32'(ovf_seen), 32'(ovf_exp));
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      rst  = 1'b1;
      cs   = 1'b1;
      sclk = 1'b0;
      mosi = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_dout", 32'(dout), 32'd0);
      check("rst_valid", 32'(dout_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_frame_err", 32'(frame_err), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      @(posedge clk);
      #2 rst = 1'b0;
      repeat (10) @(negedge clk);

      ready_mode = 1;
      send_frame(12'hAAA, W, 1'b0);
      drain("single");
      check_counts("single");
      check("idle_busy", 32'(busy), 32'd0);

      send_frame(12'h5A3, W, 1'b0);
      send_frame(12'hFFF, W, 1'b0);
      drain("b2b");

      send_frame(12'h123, 5, 1'b0);
      send_frame(12'h456, W, 1'b0);
      drain("partial");
      check_counts("partial");

      ready_mode = 0;
      for (int k = 1; k <= Depth + 1; k++) send_frame(W'(k), W, 1'b0);
      check_counts("full");
      check("full_head", 32'(dout), 32'd1);
      check("full_valid", 32'(dout_valid), 32'd1);
      ready_mode = 1;
      drain("full");

      // Reset mid-frame with a word still stored: both must vanish, no frame error.
      ready_mode = 0;
      send_frame(12'h777, W, 1'b0);
      @(negedge clk);
      cs = 1'b0;
      #H;
      drive_bits(12'h9E5, 0, 6, 1'b0, 1'b0);
      @(posedge clk);
      #2 rst = 1'b1;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      ready_mode = 1;
      @(negedge clk);
      check("post_rst_valid", 32'(dout_valid), 32'd0);
      drive_bits(12'h9E5, 6, W, 1'b0, 1'b0);
      check("arm_busy", 32'(busy), 32'd0);
      cs = 1'b1;
      #(2 * H);
      check("arm_valid", 32'(dout_valid), 32'd0);
      send_frame(12'hC3C, W, 1'b0);
      drain("rst");
      check_counts("rst");

      send_frame(12'h800, W, 1'b1);
      drain("coincide");
      check_counts("coincide");

      ready_mode = 2;
      for (int k = 0; k < 16; k++) begin
         int nb;
         nb = ($urandom_range(4, 0) == 0) ? int'($urandom_range(W - 1, 1)) : int'(W);
         send_frame(W'($urandom_range(4095, 0)), nb, 1'b0);
      end
      drain("random");
      check_counts("random");
      ready_mode = 1;

      repeat (5) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
